// File: rtl/clock_period_meter.sv
// clock_period_meter
// Samples an asynchronous pulse train and measures each complete rise-to-rise
// cycle in system clocks: high time, low time and their sum. Results leave
// through a valid/ready register stage; results that arrive while an earlier
// one is still unconsumed are counted as dropped.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   pulse_in       asynchronous input under measurement
//   out_ready      consumer accepts the held result this cycle
//   out_valid      result registers hold an unconsumed measurement
//   high_cycles    cycles the synchronized input was 1
//   low_cycles     cycles the synchronized input was 0
//   period_cycles  high_cycles + low_cycles, one bit wider
//   overflow       measurement ended by counter saturation
//   dropped        measurements lost to a stalled output (saturates at 255)
module clock_period_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W:0]   period_cycles,
    output logic             overflow,
    output logic [7:0]       dropped
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_e                 state_q;
    logic [CNT_W-1:0]       hcnt_q;
    logic [CNT_W-1:0]       lcnt_q;

    // Completed measurement waiting one cycle before the output stage.
    logic                   pub_q;
    logic [CNT_W-1:0]       pub_high_q;
    logic [CNT_W-1:0]       pub_low_q;
    logic                   pub_ovf_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prev_q <= s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            pub_q      <= 1'b0;
            pub_high_q <= '0;
            pub_low_q  <= '0;
            pub_ovf_q  <= 1'b0;
        end else begin
            pub_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Anything before the first rise is a partial cycle.
                    if (rise) begin
                        state_q <= StHigh;
                        hcnt_q  <= CntOne;
                        lcnt_q  <= '0;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        state_q <= StLow;
                        lcnt_q  <= CntOne;
                    end else if (hcnt_q == CntMax) begin
                        pub_q      <= 1'b1;
                        pub_high_q <= CntMax;
                        pub_low_q  <= '0;
                        pub_ovf_q  <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        hcnt_q <= hcnt_q + CntOne;
                    end
                end
                StLow: begin
                    if (rise) begin
                        // Closing rise also opens the next measurement.
                        pub_q      <= 1'b1;
                        pub_high_q <= hcnt_q;
                        pub_low_q  <= lcnt_q;
                        pub_ovf_q  <= 1'b0;
                        state_q    <= StHigh;
                        hcnt_q     <= CntOne;
                    end else if (lcnt_q == CntMax) begin
                        pub_q      <= 1'b1;
                        pub_high_q <= hcnt_q;
                        pub_low_q  <= CntMax;
                        pub_ovf_q  <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        lcnt_q <= lcnt_q + CntOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid     <= 1'b0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            overflow      <= 1'b0;
            dropped       <= '0;
        end else if (pub_q) begin
            if (!out_valid || out_ready) begin
                out_valid     <= 1'b1;
                high_cycles   <= pub_high_q;
                low_cycles    <= pub_low_q;
                period_cycles <= {1'b0, pub_high_q} + {1'b0, pub_low_q};
                overflow      <= pub_ovf_q;
            end else if (dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a big instance (CNT_W=16) and a small one
// (CNT_W=4) for saturation. A run-length reference model predicts results;
// a scoreboard checks every accepted result, skipping as many queued
// results as the DUT reports dropped.
module tb_clock_period_meter;

    localparam int unsigned BW = 16;
    localparam int unsigned SW = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, pulse_b, ready_b, pulse_s, ready_s;
    logic          vb, ob, vs, os;
    logic [BW-1:0] hb, lb;
    logic [BW:0]   pb;
    logic [SW-1:0] hs, ls;
    logic [SW:0]   ps;
    logic [7:0]    db, ds;

    clock_period_meter #(.CNT_W(BW), .SYNC_STAGES(2)) u_big (
        .clock(clock), .reset(reset), .pulse_in(pulse_b), .out_ready(ready_b),
        .out_valid(vb), .high_cycles(hb), .low_cycles(lb), .period_cycles(pb),
        .overflow(ob), .dropped(db)
    );

    clock_period_meter #(.CNT_W(SW), .SYNC_STAGES(2)) u_small (
        .clock(clock), .reset(reset), .pulse_in(pulse_s), .out_ready(ready_s),
        .out_valid(vs), .high_cycles(hs), .low_cycles(ls), .period_cycles(ps),
        .overflow(os), .dropped(ds)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    typedef struct {int h; int l; bit ovf;} meas_t;
    typedef struct {bit meas; bit prev; int h; int l;} mst_t;

    // Run-length model: a measurement is a full run of 1 samples followed by
    // a full run of 0 samples, bounded by rises; a run that would pass mx
    // ends the measurement with overflow and waits for a fresh rise.
    function automatic mst_t model_step(input mst_t st, input bit smp, input int mx,
                                        output bit push, output meas_t m);
        mst_t n = st;
        push = 1'b0;
        m.h = 0; m.l = 0; m.ovf = 1'b0;
        if (!st.meas) begin
            if (smp && !st.prev) begin n.meas = 1'b1; n.h = 1; n.l = 0; end
        end else if (st.l == 0) begin
            if (!smp) n.l = 1;
            else if (st.h == mx) begin
                push = 1'b1; m.h = mx; m.l = 0; m.ovf = 1'b1; n.meas = 1'b0;
            end else n.h = st.h + 1;
        end else begin
            if (smp) begin
                push = 1'b1; m.h = st.h; m.l = st.l; n.h = 1; n.l = 0;
            end else if (st.l == mx) begin
                push = 1'b1; m.h = st.h; m.l = mx; m.ovf = 1'b1; n.meas = 1'b0;
            end else n.l = st.l + 1;
        end
        n.prev = smp;
        return n;
    endfunction

    meas_t q_b[$], q_s[$];
    mst_t  st_b, st_s;
    int    acc_b = 0, acc_s = 0, last_db = 0, last_ds = 0;
    bit    hold_b = 0, hold_s = 0;
    logic [31:0] ph_b, pl_b, pp_b, po_b, ph_s, pl_s, pp_s, po_s;

    always @(negedge clock) begin
        bit    push;
        meas_t m, e;
        if (reset) begin
            q_b.delete(); st_b = '{1'b0, 1'b0, 0, 0}; last_db = 0; hold_b = 0;
        end else begin
            if (hold_b) begin
                chk("big_hold_valid", vb, 1);
                chk("big_hold_high", hb, ph_b);
                chk("big_hold_low", lb, pl_b);
                chk("big_hold_period", pb, pp_b);
                chk("big_hold_ovf", ob, po_b);
            end
            if (vb && ready_b) begin
                chk("big_result_expected", q_b.size() != 0, 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("big_high", hb, e.h);
                    chk("big_low", lb, e.l);
                    chk("big_period", pb, e.h + e.l);
                    chk("big_ovf", ob, e.ovf);
                end
                repeat (int'(db) - last_db) if (q_b.size() != 0) void'(q_b.pop_front());
                last_db = int'(db);
                acc_b++;
            end
            hold_b = vb && !ready_b;
            ph_b = hb; pl_b = lb; pp_b = pb; po_b = ob;
            st_b = model_step(st_b, pulse_b, 2**BW - 1, push, m);
            if (push) q_b.push_back(m);
        end
    end

    always @(negedge clock) begin
        bit    push;
        meas_t m, e;
        if (reset) begin
            q_s.delete(); st_s = '{1'b0, 1'b0, 0, 0}; last_ds = 0; hold_s = 0;
        end else begin
            if (hold_s) begin
                chk("small_hold_valid", vs, 1);
                chk("small_hold_high", hs, ph_s);
                chk("small_hold_low", ls, pl_s);
                chk("small_hold_period", ps, pp_s);
                chk("small_hold_ovf", os, po_s);
            end
            if (vs && ready_s) begin
                chk("small_result_expected", q_s.size() != 0, 1);
                if (q_s.size() != 0) begin
                    e = q_s.pop_front();
                    chk("small_high", hs, e.h);
                    chk("small_low", ls, e.l);
                    chk("small_period", ps, e.h + e.l);
                    chk("small_ovf", os, e.ovf);
                end
                repeat (int'(ds) - last_ds) if (q_s.size() != 0) void'(q_s.pop_front());
                last_ds = int'(ds);
                acc_s++;
            end
            hold_s = vs && !ready_s;
            ph_s = hs; pl_s = ls; pp_s = ps; po_s = os;
            st_s = model_step(st_s, pulse_s, 2**SW - 1, push, m);
            if (push) q_s.push_back(m);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wave_b(input int hi, input int lo, input int reps);
        repeat (reps) begin
            pulse_b = 1'b1; tick(hi);
            pulse_b = 1'b0; tick(lo);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(2); reset = 1'b0;
    endtask

    initial begin
        int a0;
        int len;
        reset = 1'b1; pulse_b = 1'b0; pulse_s = 1'b0; ready_b = 1'b1; ready_s = 1'b1;
        tick(4);
        // Reset state
        chk("rst_valid", vb, 0);   chk("rst_high", hb, 0);  chk("rst_low", lb, 0);
        chk("rst_period", pb, 0);  chk("rst_ovf", ob, 0);   chk("rst_dropped", db, 0);
        chk("rst_small_valid", vs, 0); chk("rst_small_dropped", ds, 0);
        reset = 1'b0;

        // 20/20 square wave, leading low partial discarded
        tick(13);
        a0 = acc_b;
        wave_b(20, 20, 6);
        pulse_b = 1'b1;
        tick(3); chk("latency_not_yet", vb, 0);
        tick(1); chk("latency_valid", vb, 1);
        chk("sq_high", hb, 20); chk("sq_low", lb, 20); chk("sq_period", pb, 40);
        chk("sq_ovf", ob, 0);
        tick(20); pulse_b = 1'b0; tick(5);
        chk("sq_count", acc_b - a0, 6);
        do_reset();

        // 3/5 wave with stalled consumer: first result held, two dropped
        tick(10);
        ready_b = 1'b0;
        wave_b(3, 5, 3);
        pulse_b = 1'b1; tick(3); pulse_b = 1'b0; tick(10);
        chk("stall_valid", vb, 1); chk("stall_high", hb, 3); chk("stall_low", lb, 5);
        chk("stall_period", pb, 8); chk("stall_dropped", db, 2);
        ready_b = 1'b1; tick(1);
        chk("drain_valid", vb, 0);
        ready_b = 1'b0;
        pulse_b = 1'b1; tick(6);
        chk("reload_valid", vb, 1); chk("reload_high", hb, 3); chk("reload_low", lb, 11);
        chk("reload_period", pb, 14); chk("reload_dropped", db, 2);
        ready_b = 1'b1; tick(2);
        pulse_b = 1'b0;
        do_reset();

        // Saturation on the CNT_W=4 instance
        tick(3);
        pulse_s = 1'b1; tick(30);
        chk("sat_high", hs, 15); chk("sat_low", ls, 0); chk("sat_period", ps, 15);
        chk("sat_ovf", os, 1);
        pulse_s = 1'b0; tick(4); pulse_s = 1'b1; tick(3); pulse_s = 1'b0; tick(4);
        pulse_s = 1'b1; tick(8);
        chk("fresh_high", hs, 3); chk("fresh_low", ls, 4); chk("fresh_period", ps, 7);
        chk("fresh_ovf", os, 0);
        pulse_s = 1'b0;

        // Toggle every clock: minimum measurement
        do_reset();
        a0 = acc_b;
        repeat (20) begin pulse_b = ~pulse_b; tick(1); end
        tick(6);
        chk("min_high", hb, 1); chk("min_low", lb, 1); chk("min_period", pb, 2);
        chk("min_count", acc_b - a0, 9);

        // Reset in mid-LOW with a held result
        do_reset();
        tick(5);
        ready_b = 1'b0;
        wave_b(20, 20, 1);
        pulse_b = 1'b1; tick(20); pulse_b = 1'b0; tick(8);
        chk("pre_rst_valid", vb, 1);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("mid_rst_valid", vb, 0); chk("mid_rst_dropped", db, 0); chk("mid_rst_high", hb, 0);
        tick(12);
        pulse_b = 1'b1; tick(20);
        chk("after_rst_no_result", vb, 0);
        pulse_b = 1'b0; tick(20); pulse_b = 1'b1; tick(6);
        chk("after_rst_valid", vb, 1); chk("after_rst_high", hb, 20);
        chk("after_rst_low", lb, 20);
        ready_b = 1'b1; tick(2); pulse_b = 1'b0;

        // Randomized waves and back-pressure on both instances
        do_reset();
        a0 = acc_b;
        for (int i = 0; i < 80; i++) begin
            pulse_b = ~pulse_b;
            len = $urandom_range(1, 12);
            repeat (len) begin
                ready_b = 1'($urandom_range(0, 1));
                ready_s = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 11) == 0) pulse_s = ~pulse_s;
                tick(1);
            end
        end
        ready_b = 1'b1; ready_s = 1'b1; pulse_b = 1'b0; pulse_s = 1'b0;
        tick(20);
        chk("rand_progress", acc_b > a0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
